// File: rtl/regfile_sb_pkg.sv
// Shared constants for the register-file slice.
//   REG_BUS      default register data width
//   REG_NUM      default number of architectural registers
//   REG_ADDR_BUS default register index width
//   REG_ZERO     index of the hardwired-zero register
//   REG_NRD/NWR  default read/write port counts
package regfile_sb_pkg;
  localparam int REG_BUS      = 64;
  localparam int REG_NUM      = 32;
  localparam int REG_ADDR_BUS = $clog2(REG_NUM);
  localparam int REG_ZERO     = 0;
  localparam int REG_NRD      = 2;
  localparam int REG_NWR      = 2;
endpackage

// File: rtl/regfile_sb_if.sv
// Decode/writeback bus of the register file.
//   master: decode + writeback side (drives writes, read indices, issue, flush)
//   slave : register file (drives rdata_o, rbusy_o)
// Multi-port fields are packed [port][bits]. This gives the same bit layout as
// the flat form, with port k at [k*W +: W].
interface regfile_sb_if
  import regfile_sb_pkg::*;
#(
  parameter int XLEN = REG_BUS,
  parameter int NREG = REG_NUM,
  parameter int NRD  = REG_NRD,
  parameter int NWR  = REG_NWR
);
  localparam int IDXW = $clog2(NREG);

  logic [NWR-1:0]           we_i;
  logic [NWR-1:0][IDXW-1:0] widx_i;
  logic [NWR-1:0][XLEN-1:0] wdata_i;
  logic [NRD-1:0][IDXW-1:0] ridx_i;
  logic [NRD-1:0][XLEN-1:0] rdata_o;
  logic [NRD-1:0]           rbusy_o;
  logic                     issue_i;
  logic [IDXW-1:0]          issue_idx_i;
  logic                     flush_i;

  modport master (
    output we_i, widx_i, wdata_i, ridx_i, issue_i, issue_idx_i, flush_i,
    input  rdata_o, rbusy_o
  );

  modport slave (
    input  we_i, widx_i, wdata_i, ridx_i, issue_i, issue_idx_i, flush_i,
    output rdata_o, rbusy_o
  );
endinterface

// File: rtl/regfile_sb_scoreboard.sv
// Pending-write scoreboard: one busy bit per architectural register.
// Ports:
//   clk, rst_n   clock, synchronous active-low reset
//   wr_hit_i     decoded write-valid vector (bit i = some port writes reg i)
//   issue_i      an instruction writing issue_idx_i is issued
//   issue_idx_i  destination of the issued instruction (0 is ignored)
//   flush_i      clear every busy bit
//   busy_o       registered busy vector, bit 0 is always 0
module regfile_scoreboard #(
  parameter int NREG = 32
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [NREG-1:0]         wr_hit_i,
  input  logic                    issue_i,
  input  logic [$clog2(NREG)-1:0] issue_idx_i,
  input  logic                    flush_i,
  output logic [NREG-1:0]         busy_o
);
  localparam int IDXW = $clog2(NREG);

  logic [NREG-1:0] busy_q, busy_d;

  // Flush beats issue; issue beats a same-cycle writeback so a fresh producer
  // is never lost to the retirement of an older one.
  always_comb begin
    busy_d = busy_q;
    for (int i = 1; i < NREG; i++) begin
      if (flush_i)                                  busy_d[i] = 1'b0;
      else if (issue_i && issue_idx_i == IDXW'(i))  busy_d[i] = 1'b1;
      else if (wr_hit_i[i])                         busy_d[i] = 1'b0;
    end
    busy_d[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) busy_q <= '0;
    else        busy_q <= busy_d;
  end

  assign busy_o = busy_q;
endmodule

// File: rtl/regfile_sb.sv
// Multi-port integer register file with a per-register pending-write scoreboard.
// Ports:
//   clk, rst_n  clock, synchronous active-low reset
//   bus         regfile_sb_if.slave: NWR write ports, NRD combinational read
//               ports (data + busy), issue and flush from decode
// Write ports resolve by index: the highest port number hitting a register wins.
// x0 is hardwired zero and never busy.
// Build option REGFILE_BYPASS_EN: reads forward same-cycle write data. A forwarded
// read is not busy unless the same cycle also issues to that register.
module regfile_sb
  import regfile_sb_pkg::*;
#(
  parameter int XLEN = REG_BUS,
  parameter int NREG = REG_NUM,
  parameter int NRD  = REG_NRD,
  parameter int NWR  = REG_NWR
) (
  input  logic       clk,
  input  logic       rst_n,
  regfile_sb_if.slave bus
);
  localparam int IDXW = $clog2(NREG);

  logic [NREG-1:0][XLEN-1:0] regs;
  logic [NREG-1:0]           wr_hit;
  logic [NREG-1:0][XLEN-1:0] wr_data;
  logic [NREG-1:0]           busy;

  // Per-register write resolve. Ports are scanned low to high, so later
  // (younger) ports overwrite earlier ones. x0 is skipped, which drops its writes.
  always_comb begin
    wr_hit  = '0;
    wr_data = '0;
    for (int i = 1; i < NREG; i++) begin
      for (int k = 0; k < NWR; k++) begin
        if (bus.we_i[k] && bus.widx_i[k] == IDXW'(i)) begin
          wr_hit[i]  = 1'b1;
          wr_data[i] = bus.wdata_i[k];
        end
      end
    end
  end

  // regs[0] is never written, so it holds its reset value of zero.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      regs <= '0;
    end else begin
      for (int i = 1; i < NREG; i++)
        if (wr_hit[i]) regs[i] <= wr_data[i];
    end
  end

  regfile_scoreboard #(.NREG(NREG)) u_sb (
    .clk         (clk),
    .rst_n       (rst_n),
    .wr_hit_i    (wr_hit),
    .issue_i     (bus.issue_i),
    .issue_idx_i (bus.issue_idx_i),
    .flush_i     (bus.flush_i),
    .busy_o      (busy)
  );

  for (genvar j = 0; j < NRD; j++) begin : g_rd
    logic [IDXW-1:0] idx;
    assign idx = bus.ridx_i[j];
`ifdef REGFILE_BYPASS_EN
    // wr_hit[0] is never set, so x0 still reads 0 and not busy.
    assign bus.rdata_o[j] = wr_hit[idx] ? wr_data[idx] : regs[idx];
    assign bus.rbusy_o[j] = wr_hit[idx] ? (bus.issue_i && bus.issue_idx_i == idx)
                                        : busy[idx];
`else
    assign bus.rdata_o[j] = regs[idx];
    assign bus.rbusy_o[j] = busy[idx];
`endif
  end
endmodule
